// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//
// Shares one downstream resource between WIDTH requesters with round-robin
// fairness. The grant is registered and held until the owner releases it
// (explicitly via i_release, or implicitly by dropping its request), so the
// winner owns the resource for a multi-cycle transaction. On release the
// arbiter re-arbitrates in the same cycle, so back-to-back grants have no
// idle bubble.
//
// Optional feature (compile-time macro ROUND_ROBIN_ARBITER_TIMEOUT_EN):
//   When defined, a grant held for MAX_HOLD busy cycles without a release is
//   force-released through the normal re-arbitration path, and o_timeout
//   pulses for one cycle. When undefined, no counter is built and o_timeout
//   is constant 0.
//
// Parameters:
//   WIDTH     number of requesters (>= 2)
//   MAX_HOLD  maximum busy cycles per grant (timeout build only, >= 1)
//
// Ports:
//   i_clock      clock, rising edge
//   i_reset      synchronous active-high reset
//   i_req        request vector, bit n = requester n
//   i_release    current owner finished (ignored while idle)
//   o_grant      registered one-hot grant, zero when idle
//   o_grant_idx  binary index of the o_grant bit, zero when idle
//   o_busy       high while o_grant is non-zero
//   o_timeout    one-cycle pulse after a forced release
// ---------------------------------------------------------------------------

// Isolates the lowest set bit of a vector.
//   vec     input vector
//   onehot  lowest set bit of vec, zero when vec is zero
//   any     high when vec is non-zero
module onehot_priority_encoder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    assign onehot = vec & (~vec + WIDTH'(1));
    assign any    = |vec;

endmodule

module round_robin_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [WIDTH-1:0]         i_req,
    input  logic                     i_release,
    output logic [WIDTH-1:0]         o_grant,
    output logic [$clog2(WIDTH)-1:0] o_grant_idx,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int unsigned IDXW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              timeout_q, timeout_d;

    logic              busy;
    logic              owner_drop;
    logic              normal_rel;
    logic              force_rel;
    logic              release_any;
    logic              grant_load;

    logic [IDXW-1:0]   pick_ptr;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  masked_req;
    logic [WIDTH-1:0]  masked_oh;
    logic              masked_any;
    logic [WIDTH-1:0]  raw_oh;
    logic              raw_any;
    logic [WIDTH-1:0]  pick;
    logic [IDXW-1:0]   pick_idx;

    function automatic logic [IDXW-1:0] to_idx(input logic [WIDTH-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (oh[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Release detection
    // ------------------------------------------------------------------
    assign busy        = |grant_q;
    assign owner_drop  = ~|(i_req & grant_q);
    assign normal_rel  = busy & (i_release | owner_drop);
    assign release_any = normal_rel | force_rel;
    assign grant_load  = ((state_q == StIdle) && (|i_req)) || release_any;

    // ------------------------------------------------------------------
    // Arbitration: while a grant is being released, the outgoing owner
    // becomes the pointer so it ends up lowest priority for this pick.
    // ------------------------------------------------------------------
    assign pick_ptr = (state_q == StGrant) ? idx_q : ptr_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            mask[i] = (IDXW'(i) > pick_ptr);
        end
    end

    assign masked_req = i_req & mask;

    onehot_priority_encoder #(
        .WIDTH (WIDTH)
    ) u_enc_masked (
        .vec    (masked_req),
        .onehot (masked_oh),
        .any    (masked_any)
    );

    onehot_priority_encoder #(
        .WIDTH (WIDTH)
    ) u_enc_raw (
        .vec    (i_req),
        .onehot (raw_oh),
        .any    (raw_any)
    );

    assign pick     = masked_any ? masked_oh : raw_oh;
    assign pick_idx = to_idx(pick);

    // ------------------------------------------------------------------
    // Optional hold-time limit
    // ------------------------------------------------------------------
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
    localparam int unsigned HOLDW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    // hold_q counts busy cycles already completed for the current grant, so
    // the MAX_HOLD-th busy cycle is the one where hold_q == MAX_HOLD-1.
    logic [HOLDW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (grant_load) begin
            hold_d = '0;
        end else if (busy) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign force_rel = busy && (hold_q == HOLDW'(MAX_HOLD - 1));
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
    assign force_rel       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (raw_any) begin
                    grant_d = pick;
                    idx_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (release_any) begin
                    ptr_d   = idx_q;
                    grant_d = pick;
                    idx_d   = pick_idx;
                    state_d = raw_any ? StGrant : StIdle;
                    // A normal release in the same cycle wins over the timeout.
                    timeout_d = force_rel & ~normal_rel;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= IDXW'(WIDTH - 1);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_idx = idx_q;
    assign o_busy      = busy;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_round_robin_arbiter
//
// Directed, table-driven bench for round_robin_arbiter (WIDTH=4, MAX_HOLD=4).
// Each table row drives reset/request/release for one cycle and gives the
// outputs expected just after the following rising edge. The hold-timeout
// sequence is hand-written because its expectation depends on the build.
// ---------------------------------------------------------------------------
module tb_round_robin_arbiter;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned MAX_HOLD = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] req;
    logic             release_in;
    logic [WIDTH-1:0] grant;
    logic [1:0]       grant_idx;
    logic             busy;
    logic             timeout;

    int total;
    int bad;

    round_robin_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_req       (req),
        .i_release   (release_in),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic [3:0] exp_grant;
        logic [1:0] exp_idx;
        logic       exp_busy;
        logic       exp_timeout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] r, input logic rel,
                                input logic [3:0] g, input logic [1:0] idx, input logic b);
        vec_t v;
        v.rst         = rst;
        v.req         = r;
        v.rel         = rel;
        v.exp_grant   = g;
        v.exp_idx     = idx;
        v.exp_busy    = b;
        v.exp_timeout = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        req        = '0;
        release_in = 1'b0;

        //   rst  req      rel   grant    idx  busy
        // Reset and idle
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // Rotation with all requesting: 0,1,2,3,0 with no idle gap
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        // Wrap/skip: grant 2, release it, then 0 then 1 win
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        // Implicit release: owner 1 drops, requester 3 wins
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
        // Other request changes ignored while held
        add(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1);
        // Release with nobody waiting goes idle; release while idle ignored
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        // Sole requester is re-granted, then drain
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // Mid-grant reset restores the pointer so requester 0 wins first
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
        add(1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            req        = vecs[i].req;
            release_in = vecs[i].rel;
            tick();
            check($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("row%0d idx", i), 32'(grant_idx), 32'(vecs[i].exp_idx));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("row%0d timeout", i), 32'(timeout), 32'(vecs[i].exp_timeout));
        end

        // Hold-timeout sequence: 0 and 1 request forever, never released.
        reset      = 1'b1;
        req        = 4'b0000;
        release_in = 1'b0;
        tick();
        reset = 1'b0;
        req   = 4'b0011;
        tick();
        check("to first grant", 32'(grant), 32'(4'b0001));
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("to hold%0d grant", k), 32'(grant), 32'(4'b0001));
            check($sformatf("to hold%0d pulse", k), 32'(timeout), 32'(1'b0));
        end
        tick();
        check("to forced grant", 32'(grant), 32'(4'b0010));
        check("to forced pulse", 32'(timeout), 32'(1'b1));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("to owner1 hold%0d grant", k), 32'(grant), 32'(4'b0010));
            check($sformatf("to owner1 hold%0d pulse", k), 32'(timeout), 32'(1'b0));
        end
        // Normal release in the limit cycle takes precedence over the timeout.
        release_in = 1'b1;
        tick();
        release_in = 1'b0;
        check("to precedence grant", 32'(grant), 32'(4'b0001));
        check("to precedence pulse", 32'(timeout), 32'(1'b0));
`else
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("to held%0d grant", k), 32'(grant), 32'(4'b0001));
            check($sformatf("to held%0d pulse", k), 32'(timeout), 32'(1'b0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
